matrix_stream_reader: RTL and testbench

Parametrised successor to the matrix file reader. Holds an N_ROWS x N_COLS matrix in internal storage and streams it element by element over a stb/ack handshake with (i, j) coordinates.
- Adds a load port so storage is written by RTL rather than by a file.
- Supports non-square matrices and arbitrary element width.
- Traverses row-major or column-major (transpose) per run.
- Has a synchronous reset that aborts a run.
Sits between matrix sources and the multiplier datapath.

---
 rtl/matrix_stream_reader_if.sv | 30 +++
 rtl/matrix_stream_reader.sv | 100 ++++++++++
 tb/tb_matrix_stream_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_reader_if.sv
// Load/stream bus between a matrix source/consumer and matrix_stream_reader.
interface matrix_stream_reader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RW     = 3,
    parameter int unsigned CW     = 3
);
    logic              wr_en;
    logic [RW-1:0]     wr_row;
    logic [CW-1:0]     wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              col_major;
    logic              value_ack;
    logic [RW-1:0]     i;
    logic [CW-1:0]     j;
    logic [DATA_W-1:0] value;
    logic              value_stb;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, start, col_major, value_ack,
        input  i, j, value, value_stb, busy, done
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, start, col_major, value_ack,
        output i, j, value, value_stb, busy, done
    );
endinterface

// File: rtl/matrix_stream_reader.sv
// Holds an N_ROWS x N_COLS matrix loaded over the bus and streams it
// element by element (row- or column-major) on a stb/ack handshake.
module matrix_stream_reader #(
    parameter int unsigned N_ROWS = 8,
    parameter int unsigned N_COLS = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_stream_reader_if.slave bus
);
    localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              mode;
    logic              wr_ok;
    logic              last_row;
    logic              last_col;
    logic [DATA_W-1:0] mem [N_ROWS][N_COLS];

    assign wr_ok = (state == IDLE) && bus.wr_en
                && (32'(bus.wr_row) < N_ROWS) && (32'(bus.wr_col) < N_COLS);
    assign last_row = (bus.i == LAST_ROW);
    assign last_col = (bus.j == LAST_COL);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
        end
    end

    assign bus.value = mem[bus.i][bus.j];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mode          <= 1'b0;
            bus.i         <= '0;
            bus.j         <= '0;
            bus.value_stb <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= READ;
                        mode          <= bus.col_major;
                        bus.i         <= '0;
                        bus.j         <= '0;
                        bus.value_stb <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                READ: begin
                    if (bus.value_ack) begin
                        if (last_row && last_col) begin
                            // Coordinates hold on the final element.
                            state         <= DONE;
                            bus.value_stb <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                        end else if (!mode) begin
                            if (last_col) begin
                                bus.j <= '0;
                                bus.i <= bus.i + RW'(1);
                            end else begin
                                bus.j <= bus.j + CW'(1);
                            end
                        end else begin
                            if (last_row) begin
                                bus.i <= '0;
                                bus.j <= bus.j + CW'(1);
                            end else begin
                                bus.i <= bus.i + RW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_stream_reader.sv
// Scoreboard bench for matrix_stream_reader: a 3x2 instance for ordering,
// stalls, abort and load rules, plus a 1x1 instance for the degenerate case.
module tb_matrix_stream_reader;
    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    matrix_stream_reader_if #(.DATA_W(16), .RW(2), .CW(1)) bus ();
    matrix_stream_reader_if #(.DATA_W(16), .RW(1), .CW(1)) bus1 ();

    matrix_stream_reader #(.N_ROWS(3), .N_COLS(2), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    matrix_stream_reader #(.N_ROWS(1), .N_COLS(1), .DATA_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    typedef struct {
        int          r;
        int          c;
        logic [15:0] v;
    } exp_t;

    exp_t        sb[$];
    bit          ack_pat[$];
    logic [15:0] model [3][2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One streaming run on the 3x2 instance; abort_after>0 resets after that many transfers.
    task automatic run_stream(input bit cm, input int abort_after, input bit inject,
                              input bit wr_with_start);
        int n = 0;
        int k = 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.col_major = cm;
        if (wr_with_start) begin
            bus.wr_en   = 1'b1;
            bus.wr_row  = 2'd2;
            bus.wr_col  = 1'd1;
            bus.wr_data = 16'hBEEF;
            model[2][1] = 16'hBEEF;
        end
        sb.delete();
        if (!cm) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 2; c++) sb.push_back('{r, c, model[r][c]});
        end else begin
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 3; r++) sb.push_back('{r, c, model[r][c]});
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        while (sb.size() > 0 && k < 100) begin
            check("stb", 32'(bus.value_stb), 32'(1));
            check("busy", 32'(bus.busy), 32'(1));
            check("done_early", 32'(bus.done), 32'(0));
            check("i", 32'(bus.i), sb[0].r);
            check("j", 32'(bus.j), sb[0].c);
            check("value", 32'(bus.value), 32'(sb[0].v));
            if (inject && k == 1) begin
                bus.wr_en   = 1'b1;
                bus.wr_row  = 2'd1;
                bus.wr_col  = 1'd1;
                bus.wr_data = 16'hBEEF;
                bus.start   = 1'b1;
            end else begin
                bus.wr_en = 1'b0;
                bus.start = 1'b0;
            end
            bus.value_ack = (ack_pat.size() > 0) ? ack_pat.pop_front() : 1'b1;
            if (bus.value_ack) begin
                void'(sb.pop_front());
                n++;
            end
            @(negedge clk);
            k++;
            if (abort_after > 0 && n == abort_after) begin
                bus.value_ack = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_stb", 32'(bus.value_stb), 32'(0));
                check("abort_busy", 32'(bus.busy), 32'(0));
                check("abort_i", 32'(bus.i), 32'(0));
                check("abort_j", 32'(bus.j), 32'(0));
                check("abort_done", 32'(bus.done), 32'(0));
                sb.delete();
                return;
            end
        end
        bus.value_ack = 1'b0;
        bus.wr_en     = 1'b0;
        bus.start     = 1'b0;
        check("timeout", 32'(sb.size()), 32'(0));
        check("transfers", n, 6);
        check("done_pulse", 32'(bus.done), 32'(1));
        check("busy_fall", 32'(bus.busy), 32'(0));
        check("stb_fall", 32'(bus.value_stb), 32'(0));
        check("final_i", 32'(bus.i), 32'(2));
        check("final_j", 32'(bus.j), 32'(1));
        @(negedge clk);
        check("done_once", 32'(bus.done), 32'(0));
        check("idle_busy", 32'(bus.busy), 32'(0));
        check("idle_stb", 32'(bus.value_stb), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        {bus.wr_en, bus.start, bus.col_major, bus.value_ack} = '0;
        bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
        {bus1.wr_en, bus1.start, bus1.col_major, bus1.value_ack} = '0;
        bus1.wr_row = '0; bus1.wr_col = '0; bus1.wr_data = '0;
        repeat (2) @(negedge clk);
        check("rst_stb", 32'(bus.value_stb), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_i", 32'(bus.i), 32'(0));
        check("rst_j", 32'(bus.j), 32'(0));
        rst = 1'b0;

        // Load mem[r][c] = 0x0100*r + c.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                bus.wr_en   = 1'b1;
                bus.wr_row  = 2'(r);
                bus.wr_col  = 1'(c);
                bus.wr_data = 16'(16'h0100 * r + c);
                model[r][c] = 16'(16'h0100 * r + c);
                @(negedge clk);
            end
        end
        bus.wr_en = 1'b0;

        run_stream(1'b0, 0, 1'b0, 1'b0);
        run_stream(1'b1, 0, 1'b0, 1'b0);
        ack_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_stream(1'b0, 0, 1'b0, 1'b0);
        run_stream(1'b0, 3, 1'b0, 1'b0);
        run_stream(1'b0, 0, 1'b0, 1'b0);
        run_stream(1'b0, 0, 1'b1, 1'b0);

        // Out-of-range row is dropped.
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'd3;
        bus.wr_col  = 1'd0;
        bus.wr_data = 16'h1234;
        @(negedge clk);
        bus.wr_en = 1'b0;
        run_stream(1'b0, 0, 1'b0, 1'b1);

        // Degenerate 1x1 matrix.
        bus1.wr_en   = 1'b1;
        bus1.wr_data = 16'hA5A5;
        @(negedge clk);
        bus1.wr_en = 1'b0;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check("one_stb", 32'(bus1.value_stb), 32'(1));
        check("one_busy", 32'(bus1.busy), 32'(1));
        check("one_value", 32'(bus1.value), 32'(16'hA5A5));
        bus1.value_ack = 1'b1;
        @(negedge clk);
        bus1.value_ack = 1'b0;
        check("one_done", 32'(bus1.done), 32'(1));
        check("one_stb_fall", 32'(bus1.value_stb), 32'(0));
        check("one_busy_fall", 32'(bus1.busy), 32'(0));
        @(negedge clk);
        check("one_done_once", 32'(bus1.done), 32'(0));
        check("one_idle_busy", 32'(bus1.busy), 32'(0));
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check("one_restart", 32'(bus1.value_stb), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
